// File: rtl/dmac_req_arbiter_if.sv
// Request/bus/engine/interrupt signal bundle for dmac_req_arbiter.
// master = arbiter side, slave = environment (peripherals, system arbiter, engine, CPU).
interface dmac_req_arbiter_if #(
  parameter int unsigned NUM_CH = 4
);
  localparam int unsigned CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] DmacReq;
  logic [NUM_CH-1:0] ReqAck;
  logic              Bus_Req;
  logic              Bus_Grant;
  logic [CH_W-1:0]   Ch_Id;
  logic              Ch_Start;
  logic              Ch_Pause;
  logic              Ch_Done;
  logic              Ch_Err;
  logic              Ch_Abort;
  logic              Busy;
  logic [NUM_CH-1:0] Irq_Status;
  logic [NUM_CH-1:0] Err_Status;
  logic [NUM_CH-1:0] Irq_Clr;
  logic              Interrupt;

  modport master (
    input  DmacReq, Bus_Grant, Ch_Done, Ch_Err, Irq_Clr,
    output ReqAck, Bus_Req, Ch_Id, Ch_Start, Ch_Pause, Ch_Abort, Busy,
           Irq_Status, Err_Status, Interrupt
  );

  modport slave (
    output DmacReq, Bus_Grant, Ch_Done, Ch_Err, Irq_Clr,
    input  ReqAck, Bus_Req, Ch_Id, Ch_Start, Ch_Pause, Ch_Abort, Busy,
           Irq_Status, Err_Status, Interrupt
  );
endinterface

// File: rtl/dmac_req_arbiter.sv
// N-channel DMAC request front-end: request latching, fixed/RR arbitration, bus handshake,
// sticky done/error interrupts. Define DMAC_WATCHDOG_EN to add the ACTIVE-phase watchdog.
module dmac_req_arbiter #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned ARB_MODE  = 0,
  parameter int unsigned TIMEOUT_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  dmac_req_arbiter_if.master   io_dmac
);
  localparam int unsigned CH_W = $clog2(NUM_CH);

  typedef enum logic [2:0] {S_IDLE, S_REQ_BUS, S_ACK, S_ACTIVE, S_RELEASE} state_t;

  state_t              r_state, w_state_nxt;
  logic [NUM_CH-1:0]   r_pend, w_pend_nxt, w_req, w_win_oh, w_act_oh, w_clr_oh;
  logic [2*NUM_CH-1:0] w_req2;
  logic [NUM_CH-1:0]   w_rot;
  logic [CH_W:0]       w_sum;
  logic [CH_W-1:0]     r_ch_id, r_ptr, w_win;
  logic                w_grant_win, w_abort;

  logic [NUM_CH-1:0]   r_req_ack, w_req_ack_nxt;
  logic [NUM_CH-1:0]   r_irq, r_err, w_irq_nxt, w_err_nxt, w_done_set, w_err_set;
  logic                r_bus_req, r_ch_start, r_busy, r_intr;
  logic                w_bus_req_nxt, w_ch_start_nxt, w_busy_nxt;

  assign w_req       = r_pend | io_dmac.DmacReq;
  assign w_win_oh    = NUM_CH'(1) << w_win;
  assign w_act_oh    = NUM_CH'(1) << r_ch_id;
  assign w_grant_win = (r_state == S_REQ_BUS) && io_dmac.Bus_Grant;

  // Winner select: highest index, or first pending at/above the pointer modulo NUM_CH
  always_comb begin
    w_win  = '0;
    w_rot  = '0;
    w_sum  = '0;
    w_req2 = {w_req, w_req};
    if (ARB_MODE == 0) begin
      for (int i = 0; i < NUM_CH; i++)
        if (w_req[i]) w_win = CH_W'(i);
    end else begin
      w_rot = NUM_CH'(w_req2 >> r_ptr);
      for (int k = NUM_CH - 1; k >= 0; k--)
        if (w_rot[k]) w_sum = (CH_W+1)'(r_ptr) + (CH_W+1)'(k);
      if (w_sum >= (CH_W+1)'(NUM_CH)) w_sum = w_sum - (CH_W+1)'(NUM_CH);
      w_win = w_sum[CH_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (|r_pend) w_state_nxt = S_REQ_BUS;
      S_REQ_BUS: if (io_dmac.Bus_Grant) w_state_nxt = S_ACK;
      S_ACK:     w_state_nxt = S_ACTIVE;
      S_ACTIVE:  if (io_dmac.Ch_Err || io_dmac.Ch_Done || w_abort) w_state_nxt = S_RELEASE;
      S_RELEASE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and status
  always_comb begin
    w_req_ack_nxt  = '0;
    w_ch_start_nxt = 1'b0;
    w_done_set     = '0;
    w_err_set      = '0;
    w_clr_oh       = '0;
    w_bus_req_nxt  = (w_state_nxt == S_REQ_BUS) || (w_state_nxt == S_ACK) ||
                     (w_state_nxt == S_ACTIVE);
    w_busy_nxt     = (w_state_nxt == S_ACTIVE);
    if (w_grant_win) begin
      w_req_ack_nxt  = w_win_oh;
      w_ch_start_nxt = 1'b1;
    end
    if (r_state == S_ACK) w_clr_oh = w_act_oh;
    if (r_state == S_ACTIVE) begin
      if (io_dmac.Ch_Err || w_abort) w_err_set  = w_act_oh;
      else if (io_dmac.Ch_Done)      w_done_set = w_act_oh;
    end
    w_pend_nxt = (r_pend & ~w_clr_oh) | io_dmac.DmacReq;
    w_irq_nxt  = w_done_set | (r_irq & ~io_dmac.Irq_Clr);
    w_err_nxt  = w_err_set  | (r_err & ~io_dmac.Irq_Clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend     <= '0;
      r_ch_id    <= '0;
      r_ptr      <= '0;
      r_req_ack  <= '0;
      r_ch_start <= 1'b0;
      r_bus_req  <= 1'b0;
      r_busy     <= 1'b0;
      r_irq      <= '0;
      r_err      <= '0;
      r_intr     <= 1'b0;
    end else begin
      r_pend     <= w_pend_nxt;
      r_req_ack  <= w_req_ack_nxt;
      r_ch_start <= w_ch_start_nxt;
      r_bus_req  <= w_bus_req_nxt;
      r_busy     <= w_busy_nxt;
      r_irq      <= w_irq_nxt;
      r_err      <= w_err_nxt;
      r_intr     <= |(r_irq | r_err);
      if (w_grant_win) r_ch_id <= w_win;
      if ((ARB_MODE != 0) && (r_state == S_RELEASE))
        r_ptr <= (r_ch_id == CH_W'(NUM_CH - 1)) ? '0 : r_ch_id + 1'b1;
    end
  end

`ifdef DMAC_WATCHDOG_EN
  logic [TIMEOUT_W-1:0] r_wd_cnt;
  logic                 r_abort;

  assign w_abort = (r_state == S_ACTIVE) && (&r_wd_cnt) && !io_dmac.Ch_Done && !io_dmac.Ch_Err;

  // Counts granted ACTIVE cycles; restarts for every transfer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd_cnt <= '0;
      r_abort  <= 1'b0;
    end else begin
      r_abort <= w_abort;
      if (r_state == S_ACK)
        r_wd_cnt <= '0;
      else if ((r_state == S_ACTIVE) && io_dmac.Bus_Grant && !(&r_wd_cnt))
        r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  assign io_dmac.Ch_Abort = r_abort;
`else
  assign w_abort          = 1'b0;
  assign io_dmac.Ch_Abort = 1'b0;
`endif

  assign io_dmac.ReqAck     = r_req_ack;
  assign io_dmac.Bus_Req    = r_bus_req;
  assign io_dmac.Ch_Id      = r_ch_id;
  assign io_dmac.Ch_Start   = r_ch_start;
  assign io_dmac.Busy       = r_busy;
  assign io_dmac.Irq_Status = r_irq;
  assign io_dmac.Err_Status = r_err;
  assign io_dmac.Interrupt  = r_intr;
  // Pause must track the grant in the same cycle, so it is not registered
  assign io_dmac.Ch_Pause   = (r_state == S_ACTIVE) && !io_dmac.Bus_Grant;
endmodule

// File: tb/tb_dmac_req_arbiter.sv
// Directed bench for dmac_req_arbiter: one fixed-priority and one round-robin instance.
module tb_dmac_req_arbiter;
  localparam int unsigned NUM_CH = 4;
  localparam logic [3:0] EXP_FIX [3] = '{4'h8, 4'h2, 4'h1};
  localparam logic [3:0] EXP_RR  [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dmac_req_arbiter_if #(.NUM_CH(NUM_CH)) if_fix ();
  dmac_req_arbiter_if #(.NUM_CH(NUM_CH)) if_rr ();

  dmac_req_arbiter #(.NUM_CH(NUM_CH), .ARB_MODE(0), .TIMEOUT_W(4)) u_fix (
    .clk(clk), .rst(rst), .io_dmac(if_fix.master));
  dmac_req_arbiter #(.NUM_CH(NUM_CH), .ARB_MODE(1), .TIMEOUT_W(4)) u_rr (
    .clk(clk), .rst(rst), .io_dmac(if_rr.master));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input bit rr, output logic [3:0] ack);
    ack = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      ack = rr ? if_rr.ReqAck : if_fix.ReqAck;
      if (ack != 4'h0) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL tb_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [3:0] ack;
    rst = 1'b0;
    if_fix.DmacReq = '0; if_fix.Bus_Grant = 1'b0; if_fix.Ch_Done = 1'b0;
    if_fix.Ch_Err  = 1'b0; if_fix.Irq_Clr = '0;
    if_rr.DmacReq  = '0; if_rr.Bus_Grant  = 1'b0; if_rr.Ch_Done  = 1'b0;
    if_rr.Ch_Err   = 1'b0; if_rr.Irq_Clr  = '0;
    repeat (2) tick();
    chk("rst_bus_req", 32'(if_fix.Bus_Req), 0);
    chk("rst_outputs", 32'({if_fix.ReqAck, if_fix.Ch_Start, if_fix.Busy, if_fix.Ch_Abort,
                            if_fix.Interrupt, if_fix.Ch_Id, if_fix.Irq_Status, if_fix.Err_Status}), 0);
    rst = 1'b1;
    if_fix.Bus_Grant = 1'b1;
    if_rr.Bus_Grant  = 1'b1;
    tick();

    // Single request on ch2: ack three cycles after the request
    if_fix.DmacReq = 4'b0100;
    tick(); if_fix.DmacReq = '0;
    chk("single_c1_ack", 32'(if_fix.ReqAck), 0);
    tick();
    chk("single_c2_bus_req", 32'(if_fix.Bus_Req), 1);
    chk("single_c2_ack", 32'(if_fix.ReqAck), 0);
    tick();
    chk("single_ack", 32'(if_fix.ReqAck), 'h4);
    chk("single_id", 32'(if_fix.Ch_Id), 2);
    chk("single_start", 32'(if_fix.Ch_Start), 1);
    tick();
    chk("single_active", 32'({if_fix.ReqAck, if_fix.Ch_Start, if_fix.Busy, if_fix.Bus_Req}), 'h3);
    if_fix.Ch_Done = 1'b1;
    tick(); if_fix.Ch_Done = 1'b0;
    chk("single_irq", 32'(if_fix.Irq_Status), 'h4);
    chk("single_release", 32'({if_fix.Bus_Req, if_fix.Busy, if_fix.Interrupt}), 0);
    tick();
    chk("single_intr", 32'(if_fix.Interrupt), 1);

    // Fixed priority, requests held until acknowledged
    if_fix.DmacReq = 4'b1011;
    for (int n = 0; n < 3; n++) begin
      wait_ack(1'b0, ack);
      chk("fixed_ack", 32'(ack), 32'(EXP_FIX[n]));
      if_fix.DmacReq = if_fix.DmacReq & ~ack;
      tick(); if_fix.Ch_Done = 1'b1;
      tick(); if_fix.Ch_Done = 1'b0;
      chk("fixed_release_bus_req", 32'(if_fix.Bus_Req), 0);
    end
    chk("fixed_irq_all", 32'(if_fix.Irq_Status), 'hF);
    if_fix.Irq_Clr = 4'hF;
    tick(); if_fix.Irq_Clr = '0;
    chk("clr_all_irq", 32'(if_fix.Irq_Status), 0);
    chk("clr_all_intr_lag", 32'(if_fix.Interrupt), 1);
    tick();
    chk("clr_all_intr", 32'(if_fix.Interrupt), 0);

    // Grant withheld in REQ_BUS, then dropped for three ACTIVE cycles
    if_fix.Bus_Grant = 1'b0;
    if_fix.DmacReq = 4'b0001;
    tick(); if_fix.DmacReq = '0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("nogrant_wait", 32'({if_fix.Bus_Req, if_fix.ReqAck}), 'h10);
      tick();
    end
    if_fix.Bus_Grant = 1'b1;
    tick();
    chk("grant_ack", 32'(if_fix.ReqAck), 'h1);
    tick();
    chk("pause_before", 32'(if_fix.Ch_Pause), 0);
    if_fix.Bus_Grant = 1'b0; #1;
    chk("pause_1", 32'(if_fix.Ch_Pause), 1);
    tick(); chk("pause_2", 32'(if_fix.Ch_Pause), 1);
    tick(); chk("pause_3", 32'(if_fix.Ch_Pause), 1);
    tick(); if_fix.Bus_Grant = 1'b1; #1;
    chk("pause_after", 32'({if_fix.Ch_Pause, if_fix.Busy}), 'h1);
    if_fix.Ch_Done = 1'b1;
    tick(); if_fix.Ch_Done = 1'b0;

    // Error beats done on ch1; write-one-to-clear both flags
    if_fix.DmacReq = 4'b0010;
    tick(); if_fix.DmacReq = '0;
    wait_ack(1'b0, ack);
    chk("err_ack", 32'(ack), 'h2);
    tick(); if_fix.Ch_Err = 1'b1; if_fix.Ch_Done = 1'b1;
    tick(); if_fix.Ch_Err = 1'b0; if_fix.Ch_Done = 1'b0;
    chk("err_status", 32'(if_fix.Err_Status), 'h2);
    chk("err_irq", 32'(if_fix.Irq_Status), 'h1);
    tick();
    chk("err_intr", 32'(if_fix.Interrupt), 1);
    if_fix.Irq_Clr = 4'b0011;
    tick(); if_fix.Irq_Clr = '0;
    chk("clr_flags", 32'({if_fix.Irq_Status, if_fix.Err_Status}), 0);
    tick();
    chk("clr_intr", 32'(if_fix.Interrupt), 0);
    if_fix.Ch_Done = 1'b1; if_fix.Ch_Err = 1'b1;
    tick(); if_fix.Ch_Done = 1'b0; if_fix.Ch_Err = 1'b0;
    tick();
    chk("idle_done_ignored", 32'({if_fix.Irq_Status, if_fix.Err_Status, if_fix.Busy}), 0);

    // Set and clear in the same cycle: set wins
    if_fix.DmacReq = 4'b0010;
    tick(); if_fix.DmacReq = '0;
    wait_ack(1'b0, ack);
    tick(); if_fix.Ch_Done = 1'b1; if_fix.Irq_Clr = 4'b0010;
    tick(); if_fix.Ch_Done = 1'b0; if_fix.Irq_Clr = '0;
    chk("set_wins_clr", 32'(if_fix.Irq_Status), 'h2);
    tick();

    // Reset mid-transfer
    if_fix.DmacReq = 4'b0100;
    tick(); if_fix.DmacReq = '0;
    wait_ack(1'b0, ack);
    tick();
    chk("pre_rst_active", 32'({if_fix.Busy, if_fix.Bus_Req, if_fix.Interrupt}), 'h7);
    rst = 1'b0; #1;
    chk("rst_async_bus_req", 32'(if_fix.Bus_Req), 0);
    chk("rst_async_outs", 32'({if_fix.ReqAck, if_fix.Ch_Start, if_fix.Busy, if_fix.Ch_Pause,
                               if_fix.Interrupt, if_fix.Ch_Id, if_fix.Irq_Status, if_fix.Err_Status}), 0);
    tick(); rst = 1'b1;
    tick();

    // Round-robin with all requests continuously asserted
    if_rr.DmacReq = 4'hF;
    for (int n = 0; n < 5; n++) begin
      wait_ack(1'b1, ack);
      chk("rr_ack", 32'(ack), 32'(EXP_RR[n]));
      tick(); if_rr.Ch_Done = 1'b1;
      tick(); if_rr.Ch_Done = 1'b0;
    end
    if_rr.DmacReq = '0;

    // Long transfer: watchdog aborts after 15 granted cycles, otherwise waits
    if_fix.DmacReq = 4'b0001;
    tick(); if_fix.DmacReq = '0;
    wait_ack(1'b0, ack);
    tick();
    repeat (15) tick();
    chk("long_pre_abort", 32'({if_fix.Ch_Abort, if_fix.Busy}), 'h1);
`ifdef DMAC_WATCHDOG_EN
    tick();
    chk("wd_abort", 32'(if_fix.Ch_Abort), 1);
    chk("wd_err", 32'({if_fix.Err_Status, if_fix.Busy}), 'h2);
    tick();
    chk("wd_abort_pulse", 32'(if_fix.Ch_Abort), 0);
`else
    repeat (10) tick();
    chk("no_wd_still_active", 32'({if_fix.Ch_Abort, if_fix.Busy, if_fix.Err_Status}), 'h10);
    if_fix.Ch_Done = 1'b1;
    tick(); if_fix.Ch_Done = 1'b0;
    chk("no_wd_done", 32'(if_fix.Irq_Status), 'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
